// File: rtl/clken_synth_pkg.sv
// Shared types and helpers for the clken_synth fractional clock-enable synthesiser.
// Build option: define CLKEN_SYNTH_PHASE_EN to build the phase-step logic.
package clken_synth_pkg;

  localparam int CFG_W    = 32;
  localparam int CFG_CH_W = 3;

  typedef struct packed {
    logic [CFG_CH_W-1:0] ch;
    logic [CFG_W-1:0]    num;
    logic [CFG_W-1:0]    den;
  } cfg_t;

  typedef enum logic {
    PS_RETARD  = 1'b0,
    PS_ADVANCE = 1'b1
  } ps_dir_e;

  function automatic logic ch_enabled(input logic [CFG_W-1:0] num,
                                      input logic [CFG_W-1:0] den);
    return (num != 32'd0) && (num <= den);
  endfunction

endpackage

// File: rtl/clken_synth_ch.sv
// One strobe channel: Bresenham num/den accumulator, lock counter and phase step.
// Phase stepping is built only when CLKEN_SYNTH_PHASE_EN is defined.
module clken_synth_ch
  import clken_synth_pkg::*;
#(
  parameter int ACC_W        = 16,
  parameter int INIT_NUM     = 6,
  parameter int INIT_DEN     = 25,
  parameter int LOCK_STROBES = 16
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             apply_i,
  input  logic [CFG_W-1:0] apply_num_i,
  input  logic [CFG_W-1:0] apply_den_i,
  input  logic             ps_valid_i,
  input  logic             ps_dir_i,
  output logic             stb_o,
  output logic             locked_o,
  output logic             enabled_o
);

  localparam int SUM_W = ACC_W + 2;
  localparam int CNT_W = (LOCK_STROBES > 0) ? $clog2(LOCK_STROBES + 1) : 1;
  localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCK_STROBES);

  logic [ACC_W-1:0] num_q, den_q, acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stb_q, locked_q, en_q;
  logic [SUM_W-1:0] add_s, sum_s, rem_s;
  logic             wrap_s, hold_s;

`ifndef CLKEN_SYNTH_PHASE_EN
  logic unused_ps_s;
  assign unused_ps_s = ps_valid_i ^ ps_dir_i;
`endif

  // Next accumulator value, wrap decision and saturating lock count.
  always_comb begin
    hold_s = 1'b0;
    add_s  = {2'b00, num_q};
`ifdef CLKEN_SYNTH_PHASE_EN
    if (ps_valid_i && (ps_dir_e'(ps_dir_i) == PS_ADVANCE)) begin
      add_s = {1'b0, num_q, 1'b0};
    end else if (ps_valid_i) begin
      hold_s = 1'b1;
    end else begin
      add_s = {2'b00, num_q};
    end
`endif
    sum_s  = {2'b00, acc_q} + add_s;
    wrap_s = !hold_s && (sum_s >= {2'b00, den_q});
    rem_s  = wrap_s ? (sum_s - {2'b00, den_q}) : sum_s;
    // A double add may leave a remainder past den; clamp so at most one wrap occurs.
    if (hold_s) begin
      acc_d = acc_q;
    end else if (rem_s >= {2'b00, den_q}) begin
      acc_d = den_q - ACC_W'(1);
    end else begin
      acc_d = rem_s[ACC_W-1:0];
    end
    if (stb_q && (cnt_q != LOCK_CNT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Channel state: reset, config apply, run, or parked while disabled.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      num_q    <= ACC_W'(INIT_NUM);
      den_q    <= ACC_W'(INIT_DEN);
      en_q     <= ch_enabled(CFG_W'(INIT_NUM), CFG_W'(INIT_DEN));
      acc_q    <= '0;
      stb_q    <= 1'b0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else if (apply_i) begin
      num_q    <= apply_num_i[ACC_W-1:0];
      den_q    <= apply_den_i[ACC_W-1:0];
      en_q     <= ch_enabled(apply_num_i, apply_den_i);
      acc_q    <= '0;
      stb_q    <= 1'b0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else if (en_q) begin
      acc_q    <= acc_d;
      stb_q    <= wrap_s;
      cnt_q    <= cnt_d;
      locked_q <= (cnt_d >= LOCK_CNT);
    end else begin
      acc_q    <= '0;
      stb_q    <= 1'b0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end
  end

  assign stb_o     = stb_q;
  assign locked_o  = locked_q;
  assign enabled_o = en_q;

endmodule

// File: rtl/clken_synth.sv
// Multi-channel fractional clock-enable synthesiser: pending config slot, handshake, channel array.
// Build option: CLKEN_SYNTH_PHASE_EN enables the ps_* phase-step inputs.
module clken_synth
  import clken_synth_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int ACC_W        = 16,
  parameter int INIT_NUM     = 6,
  parameter int INIT_DEN     = 25,
  parameter int LOCK_STROBES = 16,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_i,
  input  logic                resetn_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [CH_W-1:0]     cfg_ch_i,
  input  logic [ACC_W-1:0]    cfg_num_i,
  input  logic [ACC_W-1:0]    cfg_den_i,
  input  logic                ps_valid_i,
  input  logic [CH_W-1:0]     ps_ch_i,
  input  logic                ps_dir_i,
  output logic [CHANNELS-1:0] stb_o,
  output logic [CHANNELS-1:0] locked_o
);

  cfg_t                pend_q;
  logic                pend_vld_q, cfg_ready_q;
  logic [CHANNELS-1:0] apply_s, ps_hit_s, stb_s, locked_s, en_s;
  logic                bad_ch_s, retire_s;

  // A pending config for a channel that does not exist is dropped rather than stalling the slot.
  assign bad_ch_s = pend_vld_q && (int'(pend_q.ch) >= CHANNELS);
  assign retire_s = (|apply_s) || bad_ch_s;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign apply_s[i]  = pend_vld_q && (pend_q.ch == CFG_CH_W'(i)) && (stb_s[i] || !en_s[i]);
    assign ps_hit_s[i] = ps_valid_i && (ps_ch_i == CH_W'(i));

    clken_synth_ch #(
      .ACC_W        (ACC_W),
      .INIT_NUM     (INIT_NUM),
      .INIT_DEN     (INIT_DEN),
      .LOCK_STROBES (LOCK_STROBES)
    ) u_ch (
      .clk_i       (clk_i),
      .resetn_i    (resetn_i),
      .apply_i     (apply_s[i]),
      .apply_num_i (pend_q.num),
      .apply_den_i (pend_q.den),
      .ps_valid_i  (ps_hit_s[i]),
      .ps_dir_i    (ps_dir_i),
      .stb_o       (stb_s[i]),
      .locked_o    (locked_s[i]),
      .enabled_o   (en_s[i])
    );
  end

  // Pending config slot and the ready flag that guards it.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else if (retire_s) begin
      pend_vld_q  <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else if (cfg_valid_i && cfg_ready_q) begin
      pend_q      <= '{ch: CFG_CH_W'(cfg_ch_i), num: CFG_W'(cfg_num_i), den: CFG_W'(cfg_den_i)};
      pend_vld_q  <= 1'b1;
      cfg_ready_q <= 1'b0;
    end else begin
      pend_vld_q  <= pend_vld_q;
      cfg_ready_q <= cfg_ready_q;
    end
  end

  assign cfg_ready_o = cfg_ready_q;
  assign stb_o       = stb_s;
  assign locked_o    = locked_s;

endmodule

// File: tb/tb_clken_synth.sv
// Directed bench for clken_synth (2 channels, 16-bit, 6/25 reset rate).
module tb_clken_synth;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [0:0]  cfg_ch = 1'b0;
  logic [15:0] cfg_num = 16'd0;
  logic [15:0] cfg_den = 16'd0;
  logic        ps_valid = 1'b0;
  logic [0:0]  ps_ch = 1'b0;
  logic        ps_dir = 1'b0;
  logic [1:0]  stb;
  logic [1:0]  locked;

  int checks = 0;
  int errors = 0;
  int cnt;
  logic exp_bit;

`ifdef CLKEN_SYNTH_PHASE_EN
  localparam logic PH = 1'b1;
`else
  localparam logic PH = 1'b0;
`endif

  always #5 clk = ~clk;

  clken_synth dut (
    .clk_i       (clk),
    .resetn_i    (resetn),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_ch_i    (cfg_ch),
    .cfg_num_i   (cfg_num),
    .cfg_den_i   (cfg_den),
    .ps_valid_i  (ps_valid),
    .ps_ch_i     (ps_ch),
    .ps_dir_i    (ps_dir),
    .stb_o       (stb),
    .locked_o    (locked)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [0:0] ch, input logic [15:0] num, input logic [15:0] den);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_num   = num;
    cfg_den   = den;
    step(1);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (cfg_ready !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    chk(tag, {31'd0, cfg_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(3);
    chk("rst_stb", {30'd0, stb}, 32'd0);
    chk("rst_locked", {30'd0, locked}, 32'd0);
    chk("rst_ready", {31'd0, cfg_ready}, 32'd1);

    // Default 6/25 cadence, edges 1..50 after release
    resetn = 1'b1;
    cnt = 0;
    for (int e = 1; e <= 50; e++) begin
      step(1);
      exp_bit = e inside {5, 9, 13, 17, 21, 25, 30, 34, 38, 42, 46, 50};
      chk("stb0_pattern", {31'd0, stb[0]}, {31'd0, exp_bit});
      chk("stb1_pattern", {31'd0, stb[1]}, {31'd0, exp_bit});
      if (stb[0]) cnt++;
    end
    chk("stb0_count50", cnt, 32'd12);

    // 16th strobe is at edge 67, lock visible after edge 68
    step(17);
    chk("locked0_before", {31'd0, locked[0]}, 32'd0);
    chk("stb0_e67", {31'd0, stb[0]}, 32'd1);
    step(1);
    chk("locked0_after", {31'd0, locked[0]}, 32'd1);
    chk("locked1_after", {31'd0, locked[1]}, 32'd1);

    // Reconfigure ch1 to 1/5: transfer edge 69, ch1 strobe 71, apply 72
    cfg_write(1'b1, 16'd1, 16'd5);
    chk("ready_e69", {31'd0, cfg_ready}, 32'd0);
    step(1);
    chk("ready_e70", {31'd0, cfg_ready}, 32'd0);
    step(1);
    chk("ready_e71", {31'd0, cfg_ready}, 32'd0);
    chk("stb1_e71", {31'd0, stb[1]}, 32'd1);
    step(1);
    chk("ready_e72", {31'd0, cfg_ready}, 32'd1);
    chk("locked1_cleared", {31'd0, locked[1]}, 32'd0);
    chk("stb1_e72", {31'd0, stb[1]}, 32'd0);
    step(3);
    chk("stb0_e75", {31'd0, stb[0]}, 32'd1);
    chk("stb1_e75", {31'd0, stb[1]}, 32'd0);
    step(1);
    chk("stb1_e76", {31'd0, stb[1]}, 32'd0);
    step(1);
    chk("stb1_e77", {31'd0, stb[1]}, 32'd1);
    chk("locked0_kept", {31'd0, locked[0]}, 32'd1);
    step(1);
    chk("stb1_e78", {31'd0, stb[1]}, 32'd0);

    // num=0 disables ch1 at its next strobe (edge 82, apply 83)
    cfg_write(1'b1, 16'd0, 16'd5);
    step(3);
    chk("stb1_e82", {31'd0, stb[1]}, 32'd1);
    chk("ready_e82", {31'd0, cfg_ready}, 32'd0);
    step(1);
    chk("ready_e83", {31'd0, cfg_ready}, 32'd1);
    chk("stb1_off", {31'd0, stb[1]}, 32'd0);
    chk("locked1_off", {31'd0, locked[1]}, 32'd0);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (stb[1]) cnt++;
    end
    chk("stb1_off_count", cnt, 32'd0);

    // num > den: disabled channel applies on the next cycle and stays disabled
    cfg_write(1'b1, 16'd7, 16'd5);
    chk("ready_after_7_5", {31'd0, cfg_ready}, 32'd0);
    step(1);
    chk("ready_applied_7_5", {31'd0, cfg_ready}, 32'd1);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (stb[1]) cnt++;
    end
    chk("stb1_7_5_count", cnt, 32'd0);
    chk("locked1_7_5", {31'd0, locked[1]}, 32'd0);

    // Recovery with 2/5: apply B+1, strobes at B+4, B+6
    cfg_write(1'b1, 16'd2, 16'd5);
    step(1);
    chk("ready_applied_2_5", {31'd0, cfg_ready}, 32'd1);
    step(2);
    chk("stb1_2_5_b3", {31'd0, stb[1]}, 32'd0);
    step(1);
    chk("stb1_2_5_b4", {31'd0, stb[1]}, 32'd1);
    step(1);
    chk("stb1_2_5_b5", {31'd0, stb[1]}, 32'd0);
    step(1);
    chk("stb1_2_5_b6", {31'd0, stb[1]}, 32'd1);

    // Phase scenario on ch1 at 1/5; P is the apply edge
    cfg_write(1'b1, 16'd1, 16'd5);
    wait_ready("ready_1_5_apply");
    step(3);
    chk("ps_p3", {31'd0, stb[1]}, 32'd0);
    ps_valid = 1'b1;
    ps_ch    = 1'b1;
    ps_dir   = 1'b1;
    step(1);
    ps_valid = 1'b0;
    chk("ps_adv_p4", {31'd0, stb[1]}, {31'd0, PH});
    step(1);
    chk("ps_adv_p5", {31'd0, stb[1]}, {31'd0, ~PH});
    step(1);
    ps_valid = 1'b1;
    ps_dir   = 1'b0;
    step(1);
    ps_valid = 1'b0;
    step(2);
    chk("ps_ret_p9", {31'd0, stb[1]}, 32'd0);
    step(1);
    chk("ps_ret_p10", {31'd0, stb[1]}, 32'd1);
    step(5);
    chk("ps_p15", {31'd0, stb[1]}, 32'd1);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      if (stb[1]) cnt++;
    end
    chk("rate_100", {31'd0, (cnt >= 19 && cnt <= 21)}, 32'd1);

    // num = den on ch0: constant strobe from the first edge after apply
    cfg_write(1'b0, 16'd3, 16'd3);
    wait_ready("ready_3_3_apply");
    chk("stb0_apply_edge", {31'd0, stb[0]}, 32'd0);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      if (stb[0]) cnt++;
    end
    chk("stb0_full_rate", cnt, 32'd5);

    // Reset pulse with a config pending on ch1
    cfg_write(1'b1, 16'd1, 16'd7);
    chk("ready_pend", {31'd0, cfg_ready}, 32'd0);
    resetn = 1'b0;
    step(1);
    chk("rst2_ready", {31'd0, cfg_ready}, 32'd1);
    chk("rst2_stb", {30'd0, stb}, 32'd0);
    chk("rst2_locked", {30'd0, locked}, 32'd0);
    resetn = 1'b1;
    step(4);
    chk("rst2_e4", {30'd0, stb}, 32'd0);
    step(1);
    chk("rst2_e5", {30'd0, stb}, 32'd3);
    step(4);
    chk("rst2_e9_ch1", {31'd0, stb[1]}, 32'd1);
    chk("rst2_ready_e9", {31'd0, cfg_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
